// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared opcodes, modes and FSM states
// for the registered bitwise logic unit.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_ORN  = 3'd7
  } op_e;

  typedef enum logic {
    MODE_PAIR = 1'b0,
    MODE_FOLD = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    FOLD = 1'b1
  } state_e;

  function automatic logic is_inverting(op_e op);
    return (op == OP_NOR) || (op == OP_NAND) ||
           (op == OP_XNOR);
  endfunction

  function automatic op_e base_op(op_e op);
    op_e r;
    r = op;
    unique case (op)
      OP_NOR:  r = OP_OR;
      OP_NAND: r = OP_AND;
      OP_XNOR: r = OP_XOR;
      default: r = op;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational WIDTH-bit bitwise
// operator, shared by pairwise results and fold steps.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_e'(op_i))
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_NAND: y_o = ~(a_i & b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_ANDN: y_o = a_i & ~b_i;
      OP_ORN:  y_o = a_i | ~b_i;
    endcase
  end

endmodule

// File: rtl/logic_op_unit.sv
// logic_op_unit: registered bitwise logic unit with
// pairwise and fold modes behind valid/ready handshakes.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [LEN_W-1:0] fold_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic             out_all,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       fop_q, fop_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             accept;
  logic             pair_req;
  logic             load;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] pair_y;
  logic [WIDTH-1:0] step_y;
  logic [2:0]       step_op;
  logic [LEN_W-1:0] cnt_inc;
  logic             fold_inv;
  logic             start_inv;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pair_req = (mode_e'(mode) == MODE_PAIR) ||
                    (op[2:1] == 2'b11);
  assign step_op  = base_op(op_e'(fop_q));
  assign fold_inv = is_inverting(op_e'(fop_q));
  assign start_inv = is_inverting(op_e'(op));
  assign cnt_inc  = cnt_q + LEN_W'(1);

  logic_op_core #(.WIDTH(WIDTH)) u_pair (
    .op_i (op),
    .a_i  (in_a),
    .b_i  (in_b),
    .y_o  (pair_y)
  );

  logic_op_core #(.WIDTH(WIDTH)) u_step (
    .op_i (step_op),
    .a_i  (acc_q),
    .b_i  (in_a),
    .y_o  (step_y)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fop_d   = fop_q;
    load    = 1'b0;
    res     = out_data_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (pair_req) begin
            load = 1'b1;
            res  = pair_y;
          end else begin
            fop_d = op;
            len_d = fold_len;
            acc_d = in_a;
            cnt_d = '0;
            // one-beat burst: the reduction is just the word
            if (fold_len == '0) begin
              load = 1'b1;
              res  = in_a ^ {WIDTH{start_inv}};
            end else begin
              state_d = FOLD;
            end
          end
        end
        FOLD: begin
          acc_d = step_y;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            load    = 1'b1;
            res     = step_y ^ {WIDTH{fold_inv}};
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      fop_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fop_q   <= fop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_any   = |out_data_q;
  assign out_all   = &out_data_q;
  assign busy      = (state_q == FOLD);

endmodule

// File: tb/tb_logic_op_unit.sv
// tb_logic_op_unit: directed vectors, corner sequences
// and a randomized scoreboard against a reference model.
module tb_logic_op_unit;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   op;
  logic         mode;
  logic [L-1:0] fold_len;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_any;
  logic         out_all;
  logic         busy;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;
  logic [W-1:0] expq[$];

  logic_op_unit #(.WIDTH(W), .LEN_W(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .op        (op),
    .mode      (mode),
    .fold_len  (fold_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_any   (out_any),
    .out_all   (out_all),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  function automatic logic [W-1:0] ref_pair(
    logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    case (o)
      3'd0: r = a | b;
      3'd1: r = a & b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: r = ~(a & b);
      3'd5: r = ~(a ^ b);
      3'd6: r = a & ~b;
      default: r = a | ~b;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] ref_fold(
    logic [2:0] o, logic [W-1:0] w[$]);
    logic [W-1:0] r;
    int k;
    k = int'(o) % 3;
    r = w[0];
    for (int i = 1; i < w.size(); i++) begin
      if (k == 0)      r = r | w[i];
      else if (k == 1) r = r & w[i];
      else             r = r ^ w[i];
    end
    if (o >= 3'd3) r = ~r;
    return r;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL rand_extra: got %h expected none",
                 out_data);
      end else begin
        logic [W-1:0] e;
        e = expq.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL rand_out: got %h expected %h",
                   out_data, e);
        end
      end
    end
  end

  task automatic rand_beat(logic [W-1:0] a,
                           logic [W-1:0] b,
                           logic [2:0] o, logic m,
                           logic [L-1:0] fl);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    op = o;
    mode = m;
    fold_len = fl;
    out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL rand_stall: got in_ready=0 expected 1");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{3'd0, 8'hF0, 8'h3C, 8'hFC};
    tbl[1] = '{3'd0, 8'hA5, 8'h0F, 8'hAF};
    tbl[2] = '{3'd1, 8'hA5, 8'h0F, 8'h05};
    tbl[3] = '{3'd2, 8'hA5, 8'h0F, 8'hAA};
    tbl[4] = '{3'd3, 8'hA5, 8'h0F, 8'h50};
    tbl[5] = '{3'd4, 8'hA5, 8'h0F, 8'hFA};
    tbl[6] = '{3'd5, 8'hA5, 8'h0F, 8'h55};
    tbl[7] = '{3'd6, 8'hA5, 8'h0F, 8'hA0};
    tbl[8] = '{3'd7, 8'hA5, 8'h0F, 8'hF5};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    op = '0;
    mode = 1'b0;
    fold_len = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", W'(out_valid), 8'h00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_any_all", W'({out_any, out_all}), 8'h00);
    chk("rst_busy", W'(busy), 8'h00);
    chk("rst_in_ready", W'(in_ready), 8'h01);
    rst_n = 1'b1;
    tick();

    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      in_a = tbl[i].a;
      in_b = tbl[i].b;
      op = tbl[i].op;
      tick();
      chk($sformatf("vec%0d_valid", i), W'(out_valid), 8'h01);
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].exp);
      if (i == 0)
        chk("vec0_any_all", W'({out_any, out_all}), 8'h02);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", W'(out_valid), 8'h00);

    in_valid = 1'b1;
    op = 3'd5;
    mode = 1'b1;
    fold_len = 4'd2;
    in_a = 8'h01;
    tick();
    chk("fold_busy1", W'({busy, out_valid}), 8'h02);
    in_a = 8'h02;
    op = 3'd1;
    in_b = 8'h00;
    tick();
    chk("fold_busy2", W'({busy, out_valid}), 8'h02);
    in_a = 8'h04;
    mode = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("fold_xnor", out_data, 8'hF8);
    chk("fold_done", W'({busy, out_valid}), 8'h01);
    tick();
    chk("fold_one_out", W'(out_valid), 8'h00);

    out_ready = 1'b0;
    in_valid = 1'b1;
    mode = 1'b0;
    op = 3'd2;
    in_a = 8'hA5;
    in_b = 8'h0F;
    tick();
    in_a = 8'h11;
    in_b = 8'h22;
    op = 3'd0;
    #1;
    chk("bp_in_ready", W'(in_ready), 8'h00);
    tick();
    chk("bp_hold", out_data, 8'hAA);
    chk("bp_hold_v", W'(out_valid), 8'h01);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", W'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    chk("bp_new", out_data, 8'h33);
    tick();

    in_valid = 1'b1;
    mode = 1'b1;
    op = 3'd1;
    fold_len = 4'd1;
    in_a = 8'hFF;
    tick();
    op = 3'd0;
    in_a = 8'h0F;
    tick();
    in_valid = 1'b0;
    chk("fold_opchg", out_data, 8'h0F);
    tick();

    in_valid = 1'b1;
    mode = 1'b1;
    op = 3'd5;
    fold_len = 4'd0;
    in_a = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("fold_len0", out_data, 8'hA5);
    tick();

    in_valid = 1'b1;
    mode = 1'b1;
    op = 3'd0;
    fold_len = 4'd3;
    in_a = 8'hF0;
    tick();
    in_valid = 1'b0;
    chk("abort_busy", W'(busy), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy0", W'({busy, out_valid}), 8'h00);
    chk("abort_data", out_data, 8'h00);
    #1;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    mode = 1'b0;
    op = 3'd0;
    in_a = 8'h0C;
    in_b = 8'h03;
    tick();
    in_valid = 1'b0;
    chk("post_rst_pair", out_data, 8'h0F);
    chk("post_rst_busy", W'(busy), 8'h00);
    in_valid = 1'b1;
    mode = 1'b1;
    op = 3'd1;
    fold_len = 4'd1;
    in_a = 8'h3C;
    tick();
    in_a = 8'hF0;
    tick();
    in_valid = 1'b0;
    chk("post_rst_fold", out_data, 8'h30);
    tick();

    mon_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [2:0]   o;
      logic         m;
      logic [L-1:0] fl;
      logic [W-1:0] w[$];
      o = 3'($urandom_range(0, 7));
      m = 1'($urandom_range(0, 1));
      fl = L'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        fl = (t % 2 == 0) ? L'(0) : L'(15);
      if (!m || o >= 3'd6) begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = W'($urandom);
        expq.push_back(ref_pair(o, a, b));
        rand_beat(a, b, o, m, fl);
      end else begin
        w = {};
        for (int i = 0; i <= int'(fl); i++)
          w.push_back(W'($urandom));
        expq.push_back(ref_fold(o, w));
        for (int i = 0; i < w.size(); i++) begin
          if (i == 0)
            rand_beat(w[i], W'($urandom), o, m, fl);
          else
            rand_beat(w[i], W'($urandom),
                      3'($urandom), 1'($urandom),
                      L'($urandom));
        end
      end
      if ($urandom_range(0, 4) == 0) tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 50 && expq.size() != 0; i++)
      tick();
    tick();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending expected 0",
               expq.size());
    end
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
